uart_adc_responder: RTL and testbench
=====================================

UART_ADC_RESPONDER -- requirements
Module: uart_adc_responder

Interface
REQ-001 Parameter ID_BYTE, default 8'h41: reply byte for identify command 0x3F.
REQ-002 Parameter NAK_BYTE, default 8'hEE: reply byte for any unrecognised command.
REQ-003 clk_clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  byte from the UART core receive stream (from_uart_data).
REQ-006 rx_valid  input  1  rx_data valid (from_uart_valid).
REQ-007 rx_error  input  1  framing/parity error on the current rx byte (from_uart_error).
REQ-008 rx_ready  output  1  block accepts the rx byte (drives from_uart_ready).
REQ-009 tx_data  output  8  byte to the UART core transmit stream (to_uart_data).
REQ-010 tx_valid  output  1  tx_data valid (to_uart_valid).
REQ-011 tx_error  output  1  to_uart_error; tied 0.
REQ-012 tx_ready  input  1  UART core accepts tx byte (to_uart_ready).
REQ-013 adc_data  input  12  ADC sample word.
REQ-014 adc_valid  input  1  single-cycle strobe, adc_data valid.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 err_cnt  output  8  count of rx bytes received with rx_error set, saturating.

Function
REQ-017 An rx transfer occurs on a cycle with rx_valid & rx_ready; a tx transfer on a cycle with tx_valid & tx_ready.
REQ-018 rx_ready SHALL be high only in IDLE and GET_LEN; low in all other states.
REQ-019 While tx_valid is high, tx_data SHALL remain stable until the tx transfer; tx_valid SHALL not drop before the transfer.
REQ-020 States: IDLE, GET_LEN, SEND_HDR, WAIT_ADC, SEND_HI, SEND_LO, SEND_ONE.
REQ-021 IDLE, byte 0x53 ('S'): remaining count := 1, go to SEND_HDR.
REQ-022 IDLE, byte 0x42 ('B'): go to GET_LEN; next accepted byte N sets count := N, with N=0 meaning 256 (9-bit counter); then SEND_HDR.
REQ-023 IDLE, byte 0x3F: SEND_ONE with ID_BYTE; any other error-free byte: SEND_ONE with NAK_BYTE.
REQ-024 SEND_ONE: tx_valid high with the reply byte; on transfer, return to IDLE.
REQ-025 SEND_HDR: tx_data = 8'hA5; on transfer, go to WAIT_ADC.
REQ-026 WAIT_ADC: tx_valid low; adc_valid strobes arriving before WAIT_ADC is entered are ignored; first adc_valid in WAIT_ADC latches adc_data and moves to SEND_HI.
REQ-027 SEND_HI: tx_data = {4'h0, sample[11:8]}; SEND_LO: tx_data = sample[7:0].
REQ-028 On SEND_LO transfer: count decrements; if the new count is 0, go to IDLE, else go to WAIT_ADC (header sent once per burst).
REQ-029 Latency: command byte (or length byte) accepted in cycle t -> tx_valid high with first reply byte in cycle t+1.
REQ-030 An rx byte with rx_error=1 SHALL be consumed, not decoded, and SHALL increment err_cnt (holding at 8'hFF); in IDLE the state is unchanged; in GET_LEN the command is aborted and the state returns to IDLE with no reply.
REQ-031 rx_data in GET_LEN is never decoded as a command, including values 0x53/0x42/0x3F.
REQ-032 adc_valid coincident with entry into WAIT_ADC (same edge) is ignored; only strobes seen while in WAIT_ADC count.

Reset
REQ-033 With reset_reset high at a rising edge: state := IDLE; count, sample := 0; err_cnt := 0; tx_valid := 0; tx_data := 0; busy := 0. rx_ready is high from the first cycle after reset deasserts.
REQ-034 Reset asserted mid-burst aborts immediately with no further tx bytes, even if tx_valid was high and untransferred.

Verification
REQ-035 'S' (0x53) with tx_ready=1, adc_data=12'hABC strobed 3 cycles later -> tx bytes A5, 0A, BC; busy low after the last transfer.
REQ-036 'B' then 0x03, three samples 0x123, 0x456, 0x789 -> tx bytes A5, 01, 23, 04, 56, 07, 89; then IDLE.
REQ-037 'B' then 0x00 -> exactly 256 sample pairs after one A5 (513 bytes total).
REQ-038 0x3F -> single byte 41; 0x7A -> single byte EE; tx_ready held low 10 cycles -> tx_data stable and tx_valid high throughout.
REQ-039 rx_error=1 on 300 bytes -> err_cnt=FF, no tx activity; 'B' + errored length byte -> IDLE, no tx bytes.
REQ-040 Reset pulse during SEND_HI with tx_ready=0 -> tx_valid 0 on the next cycle; state IDLE; err_cnt 0.

Source files
------------

// File: rtl/uart_adc_responder.sv
// Command responder between a UART byte stream and a 12-bit ADC: 'S'/'B' stream samples, 0x3F identifies, others NAK.
// Reply byte valid one cycle after command/length accept; tx byte held until tx_ready, rx stalled outside IDLE/GET_LEN.
module uart_adc_responder #(
   parameter logic [7:0] ID_BYTE  = 8'h41,
   parameter logic [7:0] NAK_BYTE = 8'hEE
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_error,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        tx_error,
   input  logic        tx_ready,
   input  logic [11:0] adc_data,
   input  logic        adc_valid,
   output logic        busy,
   output logic [7:0]  err_cnt
);

   typedef enum logic [2:0] {
      IDLE, GET_LEN, SEND_HDR, WAIT_ADC, SEND_HI, SEND_LO, SEND_ONE
   } state_t;

   state_t      state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [11:0] sample_q, sample_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        rx_fire, tx_fire;

   assign rx_ready = (state_q == IDLE) || (state_q == GET_LEN);
   assign rx_fire  = rx_valid && rx_ready;
   assign tx_fire  = tx_valid_q && tx_ready;
   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign tx_error = 1'b0;
   assign busy     = (state_q != IDLE);
   assign err_cnt  = err_cnt_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sample_d   = sample_q;
      err_cnt_d  = err_cnt_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;

      if (rx_fire && rx_error && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            if (rx_fire && !rx_error) begin
               case (rx_data)
                  8'h53: begin
                     cnt_d      = 9'd1;
                     state_d    = SEND_HDR;
                     tx_valid_d = 1'b1;
                     tx_data_d  = 8'hA5;
                  end
                  8'h42: state_d = GET_LEN;
                  8'h3F: begin
                     state_d    = SEND_ONE;
                     tx_valid_d = 1'b1;
                     tx_data_d  = ID_BYTE;
                  end
                  default: begin
                     state_d    = SEND_ONE;
                     tx_valid_d = 1'b1;
                     tx_data_d  = NAK_BYTE;
                  end
               endcase
            end
         end
         GET_LEN: begin
            if (rx_fire) begin
               if (rx_error) begin
                  state_d = IDLE;
               end else begin
                  // Length 0 encodes a full 256-sample burst.
                  cnt_d      = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                  state_d    = SEND_HDR;
                  tx_valid_d = 1'b1;
                  tx_data_d  = 8'hA5;
               end
            end
         end
         SEND_HDR: begin
            if (tx_fire) begin
               state_d    = WAIT_ADC;
               tx_valid_d = 1'b0;
            end
         end
         WAIT_ADC: begin
            if (adc_valid) begin
               sample_d   = adc_data;
               state_d    = SEND_HI;
               tx_valid_d = 1'b1;
               tx_data_d  = {4'h0, adc_data[11:8]};
            end
         end
         SEND_HI: begin
            if (tx_fire) begin
               state_d   = SEND_LO;
               tx_data_d = sample_q[7:0];
            end
         end
         SEND_LO: begin
            if (tx_fire) begin
               cnt_d      = cnt_q - 9'd1;
               tx_valid_d = 1'b0;
               state_d    = (cnt_q == 9'd1) ? IDLE : WAIT_ADC;
            end
         end
         SEND_ONE: begin
            if (tx_fire) begin
               state_d    = IDLE;
               tx_valid_d = 1'b0;
            end
         end
         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sample_q   <= '0;
         err_cnt_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sample_q   <= sample_d;
         err_cnt_q  <= err_cnt_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

endmodule

// File: tb/tb_uart_adc_responder.sv
// Directed bench for uart_adc_responder: drives commands/samples, records tx transfers, checks against hand-built byte lists.
module tb_uart_adc_responder;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_error;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_error;
   logic        tx_ready;
   logic [11:0] adc_data;
   logic        adc_valid;
   logic        busy;
   logic [7:0]  err_cnt;

   int tests = 0;
   int fails = 0;
   logic [7:0] txq[$];
   logic [7:0] expq[$];

   uart_adc_responder dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_error(tx_error), .tx_ready(tx_ready),
      .adc_data(adc_data), .adc_valid(adc_valid), .busy(busy), .err_cnt(err_cnt)
   );

   always #5 clk_clk = ~clk_clk;

   // A byte seen valid&ready at the falling edge transfers on the next rising edge.
   always @(negedge clk_clk) begin
      if (!reset_reset && tx_valid && tx_ready) txq.push_back(tx_data);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic check_q(input string tag);
      bit ok;
      int bad;
      ok = (txq.size() == expq.size());
      bad = -1;
      if (ok) begin
         for (int i = 0; i < expq.size(); i++) begin
            if (ok && txq[i] !== expq[i]) begin
               ok = 1'b0;
               bad = i;
            end
         end
      end
      tests++;
      assert (ok) else begin
         fails++;
         if (bad < 0)
            $error("FAIL %s: observed %0d tx bytes required %0d", tag, txq.size(), expq.size());
         else
            $error("FAIL %s: byte %0d observed %h required %h", tag, bad, txq[bad], expq[bad]);
      end
   endtask

   task automatic clear_q();
      txq.delete();
      expq.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic err);
      rx_data  = b;
      rx_error = err;
      rx_valid = 1'b1;
      @(negedge clk_clk);
      chk("rx_ready", rx_ready, 1);
      step(1);
      rx_valid = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic adc_strobe(input logic [11:0] v);
      adc_data  = v;
      adc_valid = 1'b1;
      step(1);
      adc_valid = 1'b0;
      step(3);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_clk);
         if (busy === 1'b0) break;
      end
      chk(tag, busy, 0);
      step(1);
   endtask

   initial begin
      logic [11:0] v;
      bit stable;

      reset_reset = 1'b1;
      rx_data = '0; rx_valid = 1'b0; rx_error = 1'b0;
      tx_ready = 1'b1; adc_data = '0; adc_valid = 1'b0;
      step(2);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_tx_error", tx_error, 0);
      reset_reset = 1'b0;
      @(negedge clk_clk);
      chk("rst_rx_ready", rx_ready, 1);
      step(1);

      // Single sample burst, first reply one cycle after accept
      clear_q();
      send_byte(8'h53, 1'b0);
      chk("s_latency_valid", tx_valid, 1);
      chk("s_latency_data", tx_data, 8'hA5);
      step(2);
      adc_strobe(12'hABC);
      wait_idle("s_idle");
      expq = '{8'hA5, 8'h0A, 8'hBC};
      check_q("s_bytes");

      // Three-sample burst
      clear_q();
      send_byte(8'h42, 1'b0);
      send_byte(8'h03, 1'b0);
      step(2);
      adc_strobe(12'h123);
      adc_strobe(12'h456);
      adc_strobe(12'h789);
      wait_idle("b3_idle");
      expq = '{8'hA5, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89};
      check_q("b3_bytes");

      // Length 0 means 256 samples
      clear_q();
      send_byte(8'h42, 1'b0);
      send_byte(8'h00, 1'b0);
      step(2);
      expq.push_back(8'hA5);
      for (int i = 0; i < 256; i++) begin
         v = 12'((i * 37 + 5) & 12'hFFF);
         if (i == 255) chk("b256_busy_before_last", busy, 1);
         adc_strobe(v);
         expq.push_back({4'h0, v[11:8]});
         expq.push_back(v[7:0]);
      end
      wait_idle("b256_idle");
      chk("b256_count", txq.size(), 513);
      check_q("b256_bytes");

      // Length byte equal to a command value is only a length
      clear_q();
      send_byte(8'h42, 1'b0);
      send_byte(8'h42, 1'b0);
      step(2);
      expq.push_back(8'hA5);
      for (int i = 0; i < 66; i++) begin
         v = 12'((i * 7 + 1) & 12'hFFF);
         adc_strobe(v);
         expq.push_back({4'h0, v[11:8]});
         expq.push_back(v[7:0]);
      end
      wait_idle("blen42_idle");
      check_q("blen42_bytes");

      // Strobes before and on WAIT_ADC entry are ignored
      clear_q();
      tx_ready = 1'b0;
      adc_data = 12'h333; adc_valid = 1'b1;
      send_byte(8'h53, 1'b0);
      adc_valid = 1'b0;
      step(2);
      tx_ready = 1'b1;
      adc_data = 12'h111; adc_valid = 1'b1;
      step(1);
      adc_valid = 1'b0;
      step(3);
      @(negedge clk_clk);
      chk("coinc_tx_valid", tx_valid, 0);
      chk("coinc_busy", busy, 1);
      step(1);
      adc_strobe(12'h222);
      wait_idle("coinc_idle");
      expq = '{8'hA5, 8'h02, 8'h22};
      check_q("coinc_bytes");

      // Identify with stalled tx_ready
      clear_q();
      tx_ready = 1'b0;
      send_byte(8'h3F, 1'b0);
      chk("id_latency_valid", tx_valid, 1);
      chk("id_latency_data", tx_data, 8'h41);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_clk);
         if (!(tx_valid === 1'b1 && tx_data === 8'h41)) stable = 1'b0;
      end
      chk("id_stall_stable", stable, 1);
      chk("id_stall_busy", busy, 1);
      step(1);
      tx_ready = 1'b1;
      wait_idle("id_idle");
      expq = '{8'h41};
      check_q("id_bytes");

      // Unknown command gets NAK
      clear_q();
      send_byte(8'h7A, 1'b0);
      chk("nak_latency_data", tx_data, 8'hEE);
      wait_idle("nak_idle");
      expq = '{8'hEE};
      check_q("nak_bytes");

      // Errored length aborts the burst
      clear_q();
      send_byte(8'h42, 1'b0);
      send_byte(8'h05, 1'b1);
      step(3);
      @(negedge clk_clk);
      chk("blenerr_busy", busy, 0);
      chk("blenerr_err_cnt", err_cnt, 1);
      step(1);
      check_q("blenerr_no_tx");

      // Errored bytes in IDLE count and saturate
      clear_q();
      for (int i = 0; i < 253; i++) send_byte(8'h53, 1'b1);
      chk("err_cnt_fe", err_cnt, 8'hFE);
      for (int i = 0; i < 46; i++) send_byte(8'h3F, 1'b1);
      chk("err_cnt_sat", err_cnt, 8'hFF);
      chk("err_busy", busy, 0);
      check_q("err_no_tx");

      // Reset during SEND_HI with tx_ready low
      clear_q();
      tx_ready = 1'b0;
      send_byte(8'h42, 1'b0);
      send_byte(8'h05, 1'b0);
      tx_ready = 1'b1;
      step(2);
      tx_ready = 1'b0;
      adc_strobe(12'h9DE);
      chk("mid_hi_valid", tx_valid, 1);
      chk("mid_hi_data", tx_data, 8'h09);
      reset_reset = 1'b1;
      step(1);
      chk("mid_rst_tx_valid", tx_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err_cnt", err_cnt, 0);
      reset_reset = 1'b0;
      @(negedge clk_clk);
      chk("mid_rst_rx_ready", rx_ready, 1);
      step(1);
      tx_ready = 1'b1;
      step(5);
      chk("mid_rst_tx_valid_after", tx_valid, 0);
      expq = '{8'hA5};
      check_q("mid_rst_bytes");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
